seq_divider: RTL

//  Sequential unsigned restoring divider, the inverse of the adder datapath: repeated trial subtraction, one quotient bit per clock.

---
 rtl/seq_divider_pkg.sv | 8 +
 rtl/seq_divider_cla_sub.sv | 45 ++++
 rtl/seq_divider.sv | 106 ++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM encoding and sizing helpers for the sequential divider
package seq_divider_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/seq_divider_cla_sub.sv
// seq_divider_cla_sub: WIDTH+1-bit subtractor built from a chain of 4-bit lookahead slices
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p, c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & ci);
  assign s = p ^ c;
endmodule

module cla_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           co
);
  localparam int N = WIDTH / 4;
  logic [WIDTH:0] bn;
  logic [N:0]     c;
  assign bn = ~b;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < N; i++) begin : g_slice
    cla4 u_cla4 (
      .a (a[4*i+3:4*i]),
      .b (bn[4*i+3:4*i]),
      .ci(c[i]),
      .s (diff[4*i+3:4*i]),
      .co(c[i+1])
    );
  end
  // MSB slice: a single full adder closes the WIDTH+1-bit chain
  assign diff[WIDTH] = a[WIDTH] ^ bn[WIDTH] ^ c[N];
  assign co = (a[WIDTH] & bn[WIDTH]) | (c[N] & (a[WIDTH] ^ bn[WIDTH]));
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   r_q, r_d, rs, diff, r_nxt;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d, q_nxt, quot_q, quot_d, rem_q, rem_d;
  logic             dz_q, dz_d, no_borrow, unused_r_msb;
  assign rs = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  cla_sub #(.WIDTH(WIDTH)) u_sub (
    .a   (rs),
    .b   ({1'b0, d_q}),
    .diff(diff),
    .co  (no_borrow)
  );
  assign r_nxt = no_borrow ? diff : rs;
  assign q_nxt = {q_q[WIDTH-2:0], no_borrow};
  // R stays below D, so its top bit only matters inside the subtractor
  assign unused_r_msb = r_q[WIDTH];
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    if (clear) begin
      state_d = IDLE;
      quot_d  = '0;
      rem_d   = '0;
      dz_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          r_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          count_d = CW'(WIDTH - 1);
          state_d = (divisor == '0) ? DONE : CALC;
          if (divisor == '0) begin
            quot_d = '1;
            rem_d  = dividend;
            dz_d   = 1'b1;
          end
        end
        CALC: begin
          r_d     = r_nxt;
          q_d     = q_nxt;
          count_d = count_q - 1'b1;
          if (count_q == '0) begin
            state_d = DONE;
            quot_d  = q_nxt;
            rem_d   = r_nxt[WIDTH-1:0];
            dz_d    = 1'b0;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
endmodule
